// File: rtl/card_pkg.sv
// Card codes, active-low seven-segment patterns ({g,f,e,d,c,b,a}) and the
// baccarat-style card value used by the hand score.
package card_pkg;

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_A    = 4'd1;
  localparam logic [3:0] CARD_2    = 4'd2;
  localparam logic [3:0] CARD_3    = 4'd3;
  localparam logic [3:0] CARD_4    = 4'd4;
  localparam logic [3:0] CARD_5    = 4'd5;
  localparam logic [3:0] CARD_6    = 4'd6;
  localparam logic [3:0] CARD_7    = 4'd7;
  localparam logic [3:0] CARD_8    = 4'd8;
  localparam logic [3:0] CARD_9    = 4'd9;
  localparam logic [3:0] CARD_10   = 4'd10;
  localparam logic [3:0] CARD_J    = 4'd11;
  localparam logic [3:0] CARD_Q    = 4'd12;
  localparam logic [3:0] CARD_K    = 4'd13;

  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_10    = 7'b1000000;
  localparam logic [6:0] SEG_J     = 7'b1100001;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_K     = 7'b0001001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Ten and the court cards count zero; everything else counts face value.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    card_value = (code >= CARD_A && code <= CARD_9) ? code : 4'd0;
  endfunction

endpackage

// File: rtl/seg7_to_card.sv
// Combinational seven-segment to card-code decoder; blank and unknown
// patterns are reported separately so the FSM can treat them differently.
module seg7_to_card
  import card_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_legal,
  output logic       o_blank,
  output logic [3:0] o_code
);

  always_comb begin
    o_legal = 1'b1;
    o_blank = 1'b0;
    o_code  = CARD_NONE;
    case (i_seg)
      SEG_A:     o_code = CARD_A;
      SEG_2:     o_code = CARD_2;
      SEG_3:     o_code = CARD_3;
      SEG_4:     o_code = CARD_4;
      SEG_5:     o_code = CARD_5;
      SEG_6:     o_code = CARD_6;
      SEG_7:     o_code = CARD_7;
      SEG_8:     o_code = CARD_8;
      SEG_9:     o_code = CARD_9;
      SEG_10:    o_code = CARD_10;
      SEG_J:     o_code = CARD_J;
      SEG_Q:     o_code = CARD_Q;
      SEG_K:     o_code = CARD_K;
      SEG_BLANK: begin
        o_legal = 1'b0;
        o_blank = 1'b1;
      end
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_card_decoder.sv
// Accepts seven-segment card patterns, presents decoded cards with a
// valid/ready handshake and, when SEG7_SCORE_EN is defined, keeps a 3-card hand score.
module seg7_card_decoder
  import card_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic       seg_ready,
  input  logic       clear_hand,
  output logic [3:0] card_out,
  output logic       card_valid,
  input  logic       out_ready,
  output logic       err,
  output logic [3:0] score,
  output logic [1:0] hand_count
);

  logic       w_legal, w_blank, w_room, w_accept, w_take;
  logic [3:0] w_code;
  state_t     r_state;
  logic [3:0] r_card_out;
  logic       r_card_valid, r_err;

  seg7_to_card u_dec (
    .i_seg   (seg_in),
    .o_legal (w_legal),
    .o_blank (w_blank),
    .o_code  (w_code)
  );

  assign seg_ready  = resetb & (r_state == IDLE) & ~clear_hand & w_room;
  assign w_accept   = seg_valid & seg_ready;
  assign w_take     = (r_state == PRESENT) & out_ready & ~clear_hand;
  assign card_out   = r_card_out;
  assign card_valid = r_card_valid;
  assign err        = r_err;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state      <= IDLE;
      r_card_out   <= CARD_NONE;
      r_card_valid <= 1'b0;
      r_err        <= 1'b0;
    end else if (clear_hand) begin
      r_state      <= IDLE;
      r_card_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          if (w_legal) begin
            r_card_out   <= w_code;
            r_card_valid <= 1'b1;
            r_state      <= PRESENT;
          end else if (!w_blank) begin
            r_err <= 1'b1;
          end
        end
        PRESENT: if (w_take) begin
          r_card_valid <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SEG7_SCORE_EN
  logic [3:0] r_score, w_score_nxt;
  logic [1:0] r_hand_count;
  logic [4:0] w_sum;

  assign w_sum       = {1'b0, r_score} + {1'b0, card_value(r_card_out)};
  assign w_score_nxt = (w_sum >= 5'd10) ? 4'(w_sum - 5'd10) : w_sum[3:0];
  assign w_room      = (r_hand_count != 2'd3);
  assign score       = r_score;
  assign hand_count  = r_hand_count;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_score      <= 4'd0;
      r_hand_count <= 2'd0;
    end else if (clear_hand) begin
      r_score      <= 4'd0;
      r_hand_count <= 2'd0;
    end else if (w_take) begin
      r_score      <= w_score_nxt;
      r_hand_count <= r_hand_count + 2'd1;
    end
  end
`else
  assign w_room     = 1'b1;
  assign score      = 4'd0;
  assign hand_count = 2'd0;
`endif

endmodule

// File: tb/tb_seg7_card_decoder.sv
// Directed bench for seg7_card_decoder: decode table plus hand, stall,
// clear and asynchronous-reset sequences; score checks follow SEG7_SCORE_EN.
module tb_seg7_card_decoder;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic [6:0] seg_in = 7'h7F;
  logic       seg_valid = 1'b0, clear_hand = 1'b0, out_ready = 1'b0;
  logic       seg_ready, card_valid, err;
  logic [3:0] card_out, score;
  logic [1:0] hand_count;

  int checks = 0;
  int failures = 0;

  seg7_card_decoder dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .clear_hand (clear_hand),
    .card_out   (card_out),
    .card_valid (card_valid),
    .out_ready  (out_ready),
    .err        (err),
    .score      (score),
    .hand_count (hand_count)
  );

  always #5 slow_clock = ~slow_clock;

`ifdef SEG7_SCORE_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  typedef struct {
    logic [6:0] seg;
    logic       valid;
    logic [3:0] card;
    logic       err;
    logic [3:0] sc;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic clear();
    clear_hand = 1'b1;
    tick();
    clear_hand = 1'b0;
    #1;
  endtask

  // Offer one pattern with out_ready=1: one edge to accept, one to hand off.
  task automatic send(input logic [6:0] s);
    seg_in = s; seg_valid = 1'b1; out_ready = 1'b1;
    tick();
    seg_valid = 1'b0; seg_in = 7'h7F;
    tick();
    out_ready = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0]  = '{7'b0001000, 1'b1, 4'd1,  1'b0, 4'd1};
    vecs[1]  = '{7'b0100100, 1'b1, 4'd2,  1'b0, 4'd2};
    vecs[2]  = '{7'b0110000, 1'b1, 4'd3,  1'b0, 4'd3};
    vecs[3]  = '{7'b0011001, 1'b1, 4'd4,  1'b0, 4'd4};
    vecs[4]  = '{7'b0010010, 1'b1, 4'd5,  1'b0, 4'd5};
    vecs[5]  = '{7'b0000010, 1'b1, 4'd6,  1'b0, 4'd6};
    vecs[6]  = '{7'b1111000, 1'b1, 4'd7,  1'b0, 4'd7};
    vecs[7]  = '{7'b0000000, 1'b1, 4'd8,  1'b0, 4'd8};
    vecs[8]  = '{7'b0010000, 1'b1, 4'd9,  1'b0, 4'd9};
    vecs[9]  = '{7'b1000000, 1'b1, 4'd10, 1'b0, 4'd0};
    vecs[10] = '{7'b1100001, 1'b1, 4'd11, 1'b0, 4'd0};
    vecs[11] = '{7'b0011000, 1'b1, 4'd12, 1'b0, 4'd0};
    vecs[12] = '{7'b0001001, 1'b1, 4'd13, 1'b0, 4'd0};
    vecs[13] = '{7'b1111111, 1'b0, 4'd0,  1'b0, 4'd0};
    vecs[14] = '{7'b1010101, 1'b0, 4'd0,  1'b1, 4'd0};

    // Reset state
    #3;
    chk("rst_card_valid", card_valid, 0);
    chk("rst_seg_ready", seg_ready, 0);
    chk("rst_card_out", card_out, 0);
    chk("rst_err", err, 0);
    chk("rst_score", score, 0);
    chk("rst_hand_count", hand_count, 0);
    tick();
    resetb = 1'b1;
    #1;
    chk("idle_seg_ready", seg_ready, 1);

    // First card: 2 with out_ready held high
    seg_in = 7'b0100100; seg_valid = 1'b1; out_ready = 1'b1;
    tick();
    seg_valid = 1'b0; seg_in = 7'h7F;
    chk("two_card_valid", card_valid, 1);
    chk("two_card_out", card_out, 2);
    tick();
    out_ready = 1'b0;
    chk("two_valid_drop", card_valid, 0);
    chk("two_score", score, SC ? 2 : 0);
    chk("two_hand_count", hand_count, SC ? 1 : 0);

    // Decode table
    for (int i = 0; i < 15; i++) begin
      clear();
      seg_in = vecs[i].seg; seg_valid = 1'b1; out_ready = 1'b0;
      #1;
      chk($sformatf("tbl%0d_seg_ready", i), seg_ready, 1);
      tick();
      seg_valid = 1'b0; seg_in = 7'h7F;
      chk($sformatf("tbl%0d_card_valid", i), card_valid, vecs[i].valid);
      if (vecs[i].valid) chk($sformatf("tbl%0d_card_out", i), card_out, vecs[i].card);
      chk($sformatf("tbl%0d_err", i), err, vecs[i].err);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("tbl%0d_valid_after", i), card_valid, 0);
      chk($sformatf("tbl%0d_score", i), score, SC ? vecs[i].sc : 0);
      chk($sformatf("tbl%0d_hand_count", i), hand_count, (SC && vecs[i].valid) ? 1 : 0);
    end

    // K, 9, 7 fills the hand; a fourth offer stalls
    clear();
    send(7'b0001001);
    send(7'b0010000);
    send(7'b1111000);
    chk("hand_score", score, SC ? 6 : 0);
    chk("hand_count3", hand_count, SC ? 3 : 0);
    chk("hand_seg_ready", seg_ready, SC ? 0 : 1);
    seg_in = 7'b0000010; seg_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fourth_stalled", card_valid, SC ? 0 : 1);
    end
    seg_valid = 1'b0; seg_in = 7'h7F;
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Blank then illegal
    clear();
    seg_in = 7'b1111111; seg_valid = 1'b1; tick();
    chk("blank_no_valid", card_valid, 0);
    chk("blank_no_err", err, 0);
    seg_in = 7'b1010101; tick();
    seg_valid = 1'b0; seg_in = 7'h7F;
    chk("illegal_no_valid", card_valid, 0);
    chk("illegal_err", err, 1);
    chk("illegal_score", score, 0);
    chk("illegal_hand_count", hand_count, 0);

    // Stall in PRESENT for 5 cycles
    clear();
    seg_in = 7'b0001000; seg_valid = 1'b1; out_ready = 1'b0; tick();
    seg_valid = 1'b1; seg_in = 7'b0000000;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", card_valid, 1);
      chk("stall_card_out", card_out, 1);
      chk("stall_seg_ready", seg_ready, 0);
      tick();
    end
    seg_valid = 1'b0; seg_in = 7'h7F;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("stall_release_valid", card_valid, 0);
    chk("stall_release_score", score, SC ? 1 : 0);

    // clear_hand wins over a coincident output handshake
    clear();
    send(7'b0010010);
    send(7'b1010101);
    chk("pre_clear_score", score, SC ? 5 : 0);
    chk("pre_clear_err", err, 1);
    seg_in = 7'b0110000; seg_valid = 1'b1; tick();
    seg_valid = 1'b0; seg_in = 7'h7F;
    chk("pre_clear_valid", card_valid, 1);
    out_ready = 1'b1; clear_hand = 1'b1; tick();
    out_ready = 1'b0; clear_hand = 1'b0;
    chk("clr_card_valid", card_valid, 0);
    chk("clr_score", score, 0);
    chk("clr_hand_count", hand_count, 0);
    chk("clr_err", err, 0);

    // Asynchronous reset while a card is pending
    clear();
    send(7'b0011001);
    seg_in = 7'b1010101; seg_valid = 1'b1; tick();
    seg_in = 7'b0000000; tick();
    seg_valid = 1'b0; seg_in = 7'h7F;
    chk("pre_rst_valid", card_valid, 1);
    chk("pre_rst_err", err, 1);
    chk("pre_rst_score", score, SC ? 4 : 0);
    #2 resetb = 1'b0;
    #1;
    chk("arst_card_valid", card_valid, 0);
    chk("arst_card_out", card_out, 0);
    chk("arst_err", err, 0);
    chk("arst_score", score, 0);
    chk("arst_hand_count", hand_count, 0);
    chk("arst_seg_ready", seg_ready, 0);
    tick();
    resetb = 1'b1;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("post_rst_valid", card_valid, 0);
    chk("post_rst_score", score, 0);
    chk("post_rst_seg_ready", seg_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
